// File: rtl/fetch_stage.sv
// IF stage: PC register plus IF/ID pipeline register with stall, bubble and redirect-flush control.
// All outputs are registered (1-cycle latency); StallF/StallD hold state, and a decode redirect overrides StallF.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        PCSrcD,
    input  logic        JumpD,
    input  logic [31:0] PCBranchD,
    input  logic [31:0] InstrF,
    output logic [31:0] PCF,
    output logic [31:0] InstrD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD
);

    logic [31:0] pc_plus4_f;
    logic [31:0] jump_target;
    logic [31:0] branch_target;
    logic [31:0] redirect_target;
    logic        redirect;

    assign pc_plus4_f      = PCF + 32'd4;
    assign jump_target     = {PCPlus4D[31:28], InstrD[25:0], 2'b00};
    assign branch_target   = PCBranchD & 32'hFFFF_FFFC;
    assign redirect        = ValidD & ~StallD & (JumpD | PCSrcD);
    assign redirect_target = JumpD ? jump_target : branch_target;

    // A taken redirect wins over StallF so the resolved path is never dropped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            PCF <= RESET_PC;
        end else if (redirect) begin
            PCF <= redirect_target;
        end else if (!StallF) begin
            PCF <= pc_plus4_f;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            InstrD   <= 32'h0;
            PCPlus4D <= 32'h0;
            ValidD   <= 1'b0;
        end else if (StallD) begin
            InstrD   <= InstrD;
            PCPlus4D <= PCPlus4D;
            ValidD   <= ValidD;
        end else if (redirect || StallF) begin
            // Flush on redirect; bubble when fetch is held so nothing is duplicated.
            InstrD   <= 32'h0;
            PCPlus4D <= 32'h0;
            ValidD   <= 1'b0;
        end else begin
            InstrD   <= InstrF;
            PCPlus4D <= pc_plus4_f;
            ValidD   <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vector table, hand sequences, randomized model comparison.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        StallF, StallD, PCSrcD, JumpD;
    logic [31:0] PCBranchD;
    logic [31:0] InstrF;
    logic [31:0] PCF, InstrD, PCPlus4D;
    logic        ValidD;

    logic [31:0] instr_f_w, pcf_w, instr_d_w, pc4_d_w;
    logic        valid_d_w;

    logic [31:0] mem [0:255];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign InstrF    = mem[PCF[9:2]];
    assign instr_f_w = mem[pcf_w[9:2]];

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n), .StallF(StallF), .StallD(StallD),
        .PCSrcD(PCSrcD), .JumpD(JumpD), .PCBranchD(PCBranchD), .InstrF(InstrF),
        .PCF(PCF), .InstrD(InstrD), .PCPlus4D(PCPlus4D), .ValidD(ValidD)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .StallF(1'b0), .StallD(1'b0),
        .PCSrcD(1'b0), .JumpD(1'b0), .PCBranchD(32'h0), .InstrF(instr_f_w),
        .PCF(pcf_w), .InstrD(instr_d_w), .PCPlus4D(pc4_d_w), .ValidD(valid_d_w)
    );

    typedef struct {
        logic        rst_n;
        logic        stall_f;
        logic        stall_d;
        logic        pcsrc;
        logic        jump;
        logic [31:0] branch;
        logic [31:0] exp_pcf;
        logic [31:0] exp_instr;
        logic [31:0] exp_pc4;
        logic        exp_valid;
    } vec_t;

    vec_t vecs [19];

    // Reference model: architectural fetch/decode state after each edge.
    logic [31:0] m_pc, m_instr, m_pc4;
    logic        m_valid;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_in(input logic r, input logic sf, input logic sd,
                          input logic ps, input logic j, input logic [31:0] br);
        rst_n = r; StallF = sf; StallD = sd; PCSrcD = ps; JumpD = j; PCBranchD = br;
    endtask

    task automatic model_step();
        logic [31:0] fetched, seq_pc, target;
        logic        taken;
        fetched = mem[m_pc[9:2]];
        seq_pc  = m_pc + 32'd4;
        taken   = m_valid && !StallD && (JumpD || PCSrcD);
        if (JumpD) target = {m_pc4[31:28], m_instr[25:0], 2'b00};
        else       target = {PCBranchD[31:2], 2'b00};
        if (!rst_n) begin
            m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
        end else begin
            if (taken)        m_pc = target;
            else if (!StallF) m_pc = seq_pc;
            if (!StallD) begin
                if (taken || StallF) begin
                    m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
                end else begin
                    m_instr = fetched; m_pc4 = seq_pc; m_valid = 1'b1;
                end
            end
        end
    endtask

    // Advance one clock, update the model from the pre-edge inputs, sample after the edge.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic check_all(input string tag, input logic [31:0] pcf, input logic [31:0] ins,
                             input logic [31:0] pc4, input logic v);
        check({tag, ".PCF"}, PCF, pcf);
        check({tag, ".InstrD"}, InstrD, ins);
        check({tag, ".PCPlus4D"}, PCPlus4D, pc4);
        check({tag, ".ValidD"}, {31'h0, ValidD}, {31'h0, v});
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 + i;
        m_pc = 0; m_instr = 0; m_pc4 = 0; m_valid = 0;
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

        //           rst sf sd ps j  branch        pcf           instr         pc4           v
        vecs[0]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,   32'h0,   32'h0,         32'h0,   1'b0};
        vecs[1]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,32'h0,   32'h4,   32'hA000_0000, 32'h4,   1'b1};
        vecs[2]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,32'h0,   32'h8,   32'hA000_0001, 32'h8,   1'b1};
        vecs[3]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,32'h0,   32'hC,   32'hA000_0002, 32'hC,   1'b1};
        vecs[4]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,32'h0,   32'h10,  32'hA000_0003, 32'h10,  1'b1};
        vecs[5]  = '{1'b1,1'b1,1'b1,1'b0,1'b0,32'h0,   32'h10,  32'hA000_0003, 32'h10,  1'b1};
        vecs[6]  = '{1'b1,1'b1,1'b1,1'b0,1'b0,32'h0,   32'h10,  32'hA000_0003, 32'h10,  1'b1};
        vecs[7]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,32'h0,   32'h14,  32'hA000_0004, 32'h14,  1'b1};
        vecs[8]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,32'h0,   32'h14,  32'h0,         32'h0,   1'b0};
        vecs[9]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,32'h0,   32'h18,  32'hA000_0005, 32'h18,  1'b1};
        vecs[10] = '{1'b1,1'b0,1'b0,1'b0,1'b1,32'h0,   32'h14,  32'h0,         32'h0,   1'b0};
        vecs[11] = '{1'b1,1'b0,1'b0,1'b0,1'b1,32'h0,   32'h18,  32'hA000_0005, 32'h18,  1'b1};
        vecs[12] = '{1'b1,1'b0,1'b1,1'b1,1'b0,32'h203, 32'h1C,  32'hA000_0005, 32'h18,  1'b1};
        vecs[13] = '{1'b1,1'b0,1'b0,1'b1,1'b0,32'h203, 32'h200, 32'h0,         32'h0,   1'b0};
        vecs[14] = '{1'b1,1'b0,1'b0,1'b0,1'b0,32'h0,   32'h204, 32'hA000_0080, 32'h204, 1'b1};
        vecs[15] = '{1'b1,1'b1,1'b0,1'b1,1'b1,32'h300, 32'h200, 32'h0,         32'h0,   1'b0};
        vecs[16] = '{1'b1,1'b0,1'b0,1'b0,1'b0,32'h0,   32'h204, 32'hA000_0080, 32'h204, 1'b1};
        vecs[17] = '{1'b0,1'b0,1'b0,1'b0,1'b1,32'h0,   32'h0,   32'h0,         32'h0,   1'b0};
        vecs[18] = '{1'b1,1'b0,1'b0,1'b0,1'b0,32'h0,   32'h4,   32'hA000_0000, 32'h4,   1'b1};

        @(negedge clk);
        for (int i = 0; i < 19; i++) begin
            set_in(vecs[i].rst_n, vecs[i].stall_f, vecs[i].stall_d,
                   vecs[i].pcsrc, vecs[i].jump, vecs[i].branch);
            tick();
            check_all($sformatf("vec%0d", i), vecs[i].exp_pcf, vecs[i].exp_instr,
                      vecs[i].exp_pc4, vecs[i].exp_valid);
        end

        // Jump using a real J encoding, plus wrap-around instance after two edges.
        mem[1] = 32'h0800_0040;
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        tick();
        check("wrap.PCF", pcf_w, 32'h0000_0000);
        check("wrap.PCPlus4D", pc4_d_w, 32'h0000_0000);
        check("wrap.ValidD", {31'h0, valid_d_w}, 32'h1);
        check("jsetup.InstrD", InstrD, 32'h0800_0040);
        check("jsetup.PCPlus4D", PCPlus4D, 32'h0000_0008);
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
        tick();
        check_all("jump", 32'h0000_0100, 32'h0, 32'h0, 1'b0);

        // Randomized run against the model.
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        for (int n = 0; n < 3000; n++) begin
            set_in($urandom_range(0, 63) != 0,
                   $urandom_range(0, 3) == 0,
                   $urandom_range(0, 3) == 0,
                   $urandom_range(0, 4) == 0,
                   $urandom_range(0, 6) == 0,
                   $urandom);
            tick();
            check_all($sformatf("rand%0d", n), m_pc, m_instr, m_pc4, m_valid);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
